// File: rtl/hilo_muldiv_sequencer.sv
// hilo_muldiv_sequencer: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Operands are reduced to magnitudes at launch, WIDTH shift-add or
// restoring-subtract steps run in RUN, and signs are restored in FIXUP
// while HI/LO are written.
module hilo_muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             hilo_rd,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIXUP = 2'd2} state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    counter;

  // Latched operation context
  logic             is_div;
  logic             neg_res;     // product sign, or quotient sign
  logic             neg_rem;     // remainder takes the dividend sign
  logic             div_zero;
  logic [WIDTH-1:0] operand_b;   // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_hi;      // product high half / partial remainder
  logic [WIDTH-1:0] acc_lo;      // multiplier shifting out / quotient shifting in

  // Control strobes from the output decoder
  logic             launch;
  logic             step;
  logic             res_we;
  logic             move_we;

  // Operand magnitudes; unsigned ops (op[0]=1) pass through untouched
  logic             signed_op;
  logic             rs_neg;
  logic             rt_neg;
  logic [WIDTH-1:0] rs_mag;
  logic [WIDTH-1:0] rt_mag;

  assign signed_op = ~op[0];
  assign rs_neg    = signed_op & rs_val[WIDTH-1];
  assign rt_neg    = signed_op & rt_val[WIDTH-1];
  assign rs_mag    = rs_neg ? -rs_val : rs_val;
  assign rt_mag    = rt_neg ? -rt_val : rt_val;

  // One iteration of each algorithm
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ok;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_b} : '0);
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ok    = div_shift >= {1'b0, operand_b};
  // When the subtract succeeds the true difference is below the divisor,
  // so the low WIDTH bits hold it exactly.
  assign div_diff  = div_shift[WIDTH-1:0] - operand_b;

  // Sign correction applied in FIXUP
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign product  = {acc_hi, acc_lo};
  assign prod_fix = neg_res ? -product : product;
  // A zero divisor yields an all-ones quotient regardless of signs.
  assign quo_fix  = div_zero ? '1 : (neg_res ? -acc_lo : acc_lo);
  assign rem_fix  = neg_rem ? -acc_hi : acc_hi;
  assign res_hi   = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign res_lo   = is_div ? quo_fix : prod_fix[WIDTH-1:0];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic; flush aborts from any state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && !flush) state_next = RUN;
      RUN:     if (flush) state_next = IDLE;
               else if (counter == '0) state_next = FIXUP;
      FIXUP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output and strobe decode
  always_comb begin
    busy      = (state == RUN) || (state == FIXUP);
    stall_req = busy && (hilo_rd || mthi || mtlo || start);
    launch    = (state == IDLE) && start && !flush;
    step      = (state == RUN) && !flush;
    res_we    = (state == FIXUP) && !flush;
    move_we   = (state == IDLE) && !start && !flush;
  end

  // done pulses in the cycle after the FIXUP write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) done <= 1'b0;
    else          done <= res_we;
  end

  // Iteration datapath: load on launch, one step per RUN cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter   <= '0;
      is_div    <= 1'b0;
      neg_res   <= 1'b0;
      neg_rem   <= 1'b0;
      div_zero  <= 1'b0;
      operand_b <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
    end else if (launch) begin
      counter   <= CW'(WIDTH - 1);
      is_div    <= op[1];
      neg_res   <= rs_neg ^ rt_neg;
      neg_rem   <= rs_neg;
      div_zero  <= (rt_val == '0);
      operand_b <= op[1] ? rt_mag : rs_mag;
      acc_hi    <= '0;
      acc_lo    <= op[1] ? rs_mag : rt_mag;
    end else if (step) begin
      counter <= counter - 1'b1;
      if (is_div) begin
        acc_hi <= div_ok ? div_diff : div_shift[WIDTH-1:0];
        acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
      end else begin
        acc_hi <= mul_sum[WIDTH:1];
        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
      end
    end
  end

  // HI/LO: results from FIXUP, otherwise moves while idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi <= '0;
      lo <= '0;
    end else if (res_we) begin
      hi <= res_hi;
      lo <= res_lo;
    end else if (move_we) begin
      if (mthi) hi <= wdata;
      if (mtlo) lo <= wdata;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Directed bench for hilo_muldiv_sequencer with a cycle-level reference
// model computed from plain 64-bit arithmetic.
module tb_hilo_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        hilo_rd;
  logic        flush;
  logic        busy;
  logic        done;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hilo_muldiv_sequencer #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .wdata     (wdata),
    .hilo_rd   (hilo_rd),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .stall_req (stall_req),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result {HI, LO} of one operation
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] xa;
    logic signed [63:0] xb;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] q;
    logic signed [31:0] r;
    logic [63:0] res;
    sa = a;
    sb = b;
    xa = sa;
    xb = sb;
    res = '0;
    case (o)
      2'b00: res = xa * xb;
      2'b01: res = {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r, q};
        end
      end
      default: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  // Reference model: start edge is edge 1, HI/LO land on edge WIDTH+2
  bit          m_busy = 0;
  bit          m_done = 0;
  int          m_cnt  = 0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic [63:0] m_pend = '0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_busy = 0;
      m_done = 0;
      m_cnt  = 0;
      m_hi   = '0;
      m_lo   = '0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        if (flush) m_busy = 0;
        else begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) begin
            {m_hi, m_lo} = m_pend;
            m_busy = 0;
            m_done = 1;
          end
        end
      end else if (!flush) begin
        if (start) begin
          m_pend = ref_result(op, rs_val, rt_val);
          m_busy = 1;
          m_cnt  = 33;
        end else begin
          if (mthi) m_hi = wdata;
          if (mtlo) m_lo = wdata;
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    check("done", {31'd0, done}, {31'd0, m_done});
    check("stall_req", {31'd0, stall_req},
          {31'd0, m_busy & (hilo_rd | mthi | mtlo | start)});
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
  end

  task automatic wait_done(output int cycles);
    bit got;
    got = 0;
    cycles = -1;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        got = 1;
        cycles = i;
        break;
      end
      @(negedge clk);
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic mv,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    @(negedge clk);
    op = o; rs_val = a; rt_val = b; start = 1; mthi = mv; wdata = 32'hDEAD;
    @(negedge clk);
    start = 0; mthi = 0;
    wait_done(cyc);
    $display("op %s: rs=%h rt=%h -> hi=%h lo=%h done after %0d cycles", name, a, b, hi, lo, cyc);
    check({name, "_latency"}, cyc, 33);
    check({name, "_hi"}, hi, exp_hi);
    check({name, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    int cyc;
    reset_n = 0; start = 0; op = 0; rs_val = 0; rt_val = 0;
    mthi = 0; mtlo = 0; wdata = 0; hilo_rd = 0; flush = 0;
    repeat (3) @(negedge clk);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_done", {31'd0, done}, 0);
    check("reset_stall", {31'd0, stall_req}, 0);
    reset_n = 1;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd5,         0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,         0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_zero", 2'b11, 32'd7,         32'd0,         0, 32'd7,         32'hFFFF_FFFF);
    run_op("div_zero",  2'b10, 32'hFFFF_FFF9, 32'd0,         0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'd0,         32'h8000_0000);
    run_op("mult_min",  2'b00, 32'h8000_0000, 32'h8000_0000, 0, 32'h4000_0000, 32'd0);

    // Second start and hilo_rd held while busy: stalled, then ignored
    @(negedge clk);
    op = 2'b01; rs_val = 32'd6; rt_val = 32'd7; start = 1;
    @(negedge clk);
    op = 2'b11; rs_val = 32'd100; rt_val = 32'd7; hilo_rd = 1;
    for (int i = 0; i < 60; i++) begin
      if (done) break;
      if (i < 3) check("stall_busy", {31'd0, stall_req}, 1);
      @(negedge clk);
    end
    start = 0;
    check("stall_done_cycle", {31'd0, stall_req}, 0);
    check("stall_first_lo", lo, 32'd42);
    $display("stall: first op done hi=%h lo=%h", hi, lo);
    @(negedge clk);
    hilo_rd = 0;
    check("second_not_run", {31'd0, busy}, 0);
    run_op("divu_repr", 2'b11, 32'd100, 32'd7, 0, 32'd2, 32'd14);

    // Flush around RUN cycle 10
    @(negedge clk);
    op = 2'b00; rs_val = 32'd9; rt_val = 32'd9; start = 1;
    @(negedge clk);
    start = 0;
    repeat (9) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    check("flush_busy", {31'd0, busy}, 0);
    check("flush_hi", hi, 32'd2);
    check("flush_lo", lo, 32'd14);
    $display("flush: busy=%b hi=%h lo=%h", busy, hi, lo);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) check("flush_no_done", 32'd1, 32'd0);
    end

    // Moves while idle
    @(negedge clk);
    mtlo = 1; wdata = 32'h1234;
    @(negedge clk);
    mtlo = 0;
    check("mtlo_lo", lo, 32'h1234);
    check("mtlo_hi", hi, 32'd2);
    $display("mtlo: hi=%h lo=%h", hi, lo);
    mthi = 1; mtlo = 1; wdata = 32'hABCD;
    @(negedge clk);
    mthi = 0; mtlo = 0;
    check("mtboth_hi", hi, 32'hABCD);
    check("mtboth_lo", lo, 32'hABCD);
    $display("mthi+mtlo: hi=%h lo=%h", hi, lo);

    // start wins over a same-cycle mthi
    run_op("start_vs_mthi", 2'b01, 32'd3, 32'd4, 1, 32'd0, 32'd12);

    // Asynchronous reset mid-RUN
    @(negedge clk);
    op = 2'b01; rs_val = 32'd5; rt_val = 32'd5; start = 1;
    @(negedge clk);
    start = 0;
    repeat (5) @(negedge clk);
    #2 reset_n = 0;
    #1;
    check("async_rst_hi", hi, 0);
    check("async_rst_lo", lo, 0);
    check("async_rst_busy", {31'd0, busy}, 0);
    $display("async reset: hi=%h lo=%h busy=%b", hi, lo, busy);
    @(negedge clk);
    reset_n = 1;
    run_op("after_reset", 2'b11, 32'd50, 32'd6, 0, 32'd2, 32'd8);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
